// File: rtl/windowed_register_file.sv
// Windowed register file: 8 globals plus NWINDOWS overlapping windows of
// 8 outs and 8 locals each, with save/restore window shifting and
// registered overflow/underflow trap pulses.
module windowed_register_file #(
  parameter int WIDTH    = 32,
  parameter int NWINDOWS = 4,
  parameter int BYPASS   = 1,
  localparam int CW      = $clog2(NWINDOWS)
) (
  input  logic                Clk,
  input  logic                Clr,
  input  logic [4:0]          RA,
  input  logic [4:0]          RB,
  input  logic [4:0]          RD,
  input  logic [WIDTH-1:0]    D,
  input  logic                Le,
  input  logic                Save,
  input  logic                Restore,
  input  logic [NWINDOWS-1:0] WIM,
  output logic [WIDTH-1:0]    QA,
  output logic [WIDTH-1:0]    QB,
  output logic [CW-1:0]       CWP,
  output logic                Trap_Ovf,
  output logic                Trap_Unf
);

  localparam int NREG = 8 + 16 * NWINDOWS;
  localparam int PW   = $clog2(NREG);

  // Physical layout: globals at 0..7, then window w occupies 16 entries
  // starting at 8+16*w (outs first, locals next). Logical r8..r23 are
  // therefore one contiguous run; r24..r31 are the outs of window w+1.
  function automatic logic [PW-1:0] phys_index(input logic [4:0] r,
                                               input logic [CW-1:0] w);
    int ri;
    int wi;
    int idx;
    ri = int'(r);
    wi = int'(w);
    if (ri < 8) begin
      idx = ri;
    end else if (ri < 24) begin
      idx = 8 + 16 * wi + (ri - 8);
    end else begin
      idx = 8 + 16 * ((wi + 1) % NWINDOWS) + (ri - 24);
    end
    return PW'(idx);
  endfunction

  logic [WIDTH-1:0] regs [NREG];
  logic [CW-1:0]    cwp_q;
  logic             ovf_q;
  logic             unf_q;

  logic [CW-1:0]    cwp_inc;
  logic [CW-1:0]    cwp_dec;
  logic             save_only;
  logic             restore_only;
  logic             ovf_req;
  logic             unf_req;
  logic [CW-1:0]    cwp_nxt;
  logic [PW-1:0]    wr_idx;
  logic [PW-1:0]    ra_idx;
  logic [PW-1:0]    rb_idx;
  logic             wr_en;

  assign CWP      = cwp_q;
  assign Trap_Ovf = ovf_q;
  assign Trap_Unf = unf_q;

  // Neighbouring window indices, wrapped explicitly so non-power-of-2
  // window counts stay in range.
  always_comb begin
    cwp_inc = (cwp_q == CW'(NWINDOWS - 1)) ? '0 : cwp_q + CW'(1);
    cwp_dec = (cwp_q == '0) ? CW'(NWINDOWS - 1) : cwp_q - CW'(1);
  end

  // Window-shift decision: a shift into an invalid window traps instead.
  always_comb begin
    save_only    = Save & ~Restore;
    restore_only = Restore & ~Save;
    ovf_req      = save_only & WIM[cwp_dec];
    unf_req      = restore_only & WIM[cwp_inc];
    cwp_nxt      = cwp_q;
    if (save_only && !WIM[cwp_dec]) begin
      cwp_nxt = cwp_dec;
    end else if (restore_only && !WIM[cwp_inc]) begin
      cwp_nxt = cwp_inc;
    end
  end

  // Address translation for the write port and both read ports.
  always_comb begin
    wr_en  = Le & (RD != 5'd0);
    wr_idx = phys_index(RD, cwp_q);
    ra_idx = phys_index(RA, cwp_q);
    rb_idx = phys_index(RB, cwp_q);
  end

  // Window pointer and trap pulses; trap flags are rewritten every cycle
  // so each pulse lasts exactly one cycle.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      cwp_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cwp_q <= cwp_nxt;
      ovf_q <= ovf_req;
      unf_q <= unf_req;
    end
  end

  // Register storage; the write uses the pre-edge window pointer.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_idx] <= D;
    end
  end

  // Read port A: r0 is hardwired to zero, optional same-cycle forwarding.
  always_comb begin
    QA = '0;
    if (RA != 5'd0) begin
      if ((BYPASS != 0) && Le && (RD == RA)) begin
        QA = D;
      end else begin
        QA = regs[ra_idx];
      end
    end
  end

  // Read port B: same behaviour as port A.
  always_comb begin
    QB = '0;
    if (RB != 5'd0) begin
      if ((BYPASS != 0) && Le && (RD == RB)) begin
        QB = D;
      end else begin
        QB = regs[rb_idx];
      end
    end
  end

endmodule

// File: tb/tb_windowed_register_file.sv
// Self-checking bench: two instances (forwarding on/off) driven in
// lock-step, compared against a behavioural window model via a scoreboard.
module tb_windowed_register_file;

  localparam int W  = 32;
  localparam int NW = 4;

  logic          Clk;
  logic          Clr;
  logic [4:0]    RA, RB, RD;
  logic [W-1:0]  D;
  logic          Le, Save, Restore;
  logic [NW-1:0] WIM;
  logic [W-1:0]  qa, qb, qa_nb, qb_nb;
  logic [1:0]    cwp, cwp_nb;
  logic          ovf, unf, ovf_nb, unf_nb;

  windowed_register_file #(.WIDTH(W), .NWINDOWS(NW), .BYPASS(1)) dut (
    .Clk(Clk), .Clr(Clr), .RA(RA), .RB(RB), .RD(RD), .D(D), .Le(Le),
    .Save(Save), .Restore(Restore), .WIM(WIM), .QA(qa), .QB(qb),
    .CWP(cwp), .Trap_Ovf(ovf), .Trap_Unf(unf)
  );

  windowed_register_file #(.WIDTH(W), .NWINDOWS(NW), .BYPASS(0)) dut_nb (
    .Clk(Clk), .Clr(Clr), .RA(RA), .RB(RB), .RD(RD), .D(D), .Le(Le),
    .Save(Save), .Restore(Restore), .WIM(WIM), .QA(qa_nb), .QB(qb_nb),
    .CWP(cwp_nb), .Trap_Ovf(ovf_nb), .Trap_Unf(unf_nb)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string        tag;
    logic [W-1:0] val;
  } exp_t;
  exp_t sb[$];

  // behavioural model: globals and per-window out/local banks
  logic [W-1:0] m_glob [8];
  logic [W-1:0] m_outs [NW][8];
  logic [W-1:0] m_locs [NW][8];
  int           m_cwp;
  logic         m_ovf, m_unf;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic push_exp(input string tag, input logic [W-1:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic pop_check(input logic [W-1:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_underflow", obs, 'x);
    end else begin
      e = sb.pop_front();
      chk(e.tag, obs, e.val);
    end
  endtask

  function automatic logic [W-1:0] mread(input int r);
    if (r == 0) return '0;
    if (r < 8) return m_glob[r];
    if (r < 16) return m_outs[m_cwp][r-8];
    if (r < 24) return m_locs[m_cwp][r-16];
    return m_outs[(m_cwp + 1) % NW][r-24];
  endfunction

  task automatic model_edge(input logic le, input int rd, input logic [W-1:0] d,
                            input logic sv, input logic rs, input logic [NW-1:0] wim,
                            input logic clr);
    int nb;
    if (clr) begin
      for (int i = 0; i < 8; i++) m_glob[i] = '0;
      for (int w = 0; w < NW; w++)
        for (int i = 0; i < 8; i++) begin
          m_outs[w][i] = '0;
          m_locs[w][i] = '0;
        end
      m_cwp = 0; m_ovf = 0; m_unf = 0;
    end else begin
      if (le && rd != 0) begin
        if (rd < 8) m_glob[rd] = d;
        else if (rd < 16) m_outs[m_cwp][rd-8] = d;
        else if (rd < 24) m_locs[m_cwp][rd-16] = d;
        else m_outs[(m_cwp + 1) % NW][rd-24] = d;
      end
      m_ovf = 0; m_unf = 0;
      if (sv && !rs) begin
        nb = (m_cwp + NW - 1) % NW;
        if (wim[nb]) m_ovf = 1; else m_cwp = nb;
      end else if (rs && !sv) begin
        nb = (m_cwp + 1) % NW;
        if (wim[nb]) m_unf = 1; else m_cwp = nb;
      end
    end
  endtask

  task automatic check_state(input string tag);
    push_exp({tag, " cwp"}, W'(m_cwp));
    push_exp({tag, " ovf"}, W'(m_ovf));
    push_exp({tag, " unf"}, W'(m_unf));
    push_exp({tag, " cwp_nb"}, W'(m_cwp));
    pop_check(W'(cwp));
    pop_check(W'(ovf));
    pop_check(W'(unf));
    pop_check(W'(cwp_nb));
  endtask

  task automatic cycle(input string tag, input logic le, input int rd, input logic [W-1:0] d,
                       input logic sv, input logic rs, input logic [NW-1:0] wim,
                       input logic clr);
    Le = le; RD = 5'(rd); D = d; Save = sv; Restore = rs; WIM = wim; Clr = clr;
    @(posedge Clk);
    model_edge(le, rd, d, sv, rs, wim, clr);
    #1;
    Le = 0; Save = 0; Restore = 0; Clr = 0;
    check_state(tag);
  endtask

  task automatic rd_chk(input int ra, input int rb);
    RA = 5'(ra); RB = 5'(rb);
    #1;
    push_exp($sformatf("qa r%0d w%0d", ra, m_cwp), mread(ra));
    push_exp($sformatf("qb r%0d w%0d", rb, m_cwp), mread(rb));
    push_exp($sformatf("qa_nb r%0d w%0d", ra, m_cwp), mread(ra));
    push_exp($sformatf("qb_nb r%0d w%0d", rb, m_cwp), mread(rb));
    pop_check(qa);
    pop_check(qb);
    pop_check(qa_nb);
    pop_check(qb_nb);
  endtask

  initial begin
    logic          le, sv, rs, clr;
    int            rd, rb;
    logic [W-1:0]  d;
    logic [NW-1:0] wim;

    Clr = 1; Le = 0; Save = 0; Restore = 0; RA = 0; RB = 0; RD = 0; D = '0; WIM = '0;
    m_cwp = 0; m_ovf = 0; m_unf = 0;
    @(negedge Clk);
    cycle("reset", 0, 0, '0, 0, 0, '0, 1);
    rd_chk(1, 31);

    // r5 write, r0 write discarded
    cycle("w_r5", 1, 5, 32'hDEADBEEF, 0, 0, '0, 0);
    cycle("w_r0", 1, 0, 32'h1, 0, 0, '0, 0);
    RA = 5; RB = 0; #1;
    push_exp("r5_const", 32'hDEADBEEF);
    push_exp("r0_const", 32'h0);
    pop_check(qa);
    pop_check(qb);
    rd_chk(5, 0);

    // outs of window 0 become ins of window 3 after a save
    cycle("w_r8", 1, 8, 32'h11, 0, 0, '0, 0);
    cycle("save_ok", 0, 0, '0, 1, 0, '0, 0);
    push_exp("cwp_after_save", 32'd3);
    pop_check(W'(cwp));
    RA = 24; RB = 8; #1;
    push_exp("r24_new_win", 32'h11);
    push_exp("r8_new_win", 32'h0);
    pop_check(qa);
    pop_check(qb);

    // back to window 0, then overflow trap and restore walk
    cycle("restore_wrap", 0, 0, '0, 0, 1, '0, 0);
    cycle("save_trap", 0, 0, '0, 1, 0, 4'b1000, 0);
    push_exp("ovf_pulse", 32'd1);
    pop_check(W'(ovf));
    cycle("trap_clear", 0, 0, '0, 0, 0, '0, 0);
    for (int i = 0; i < 4; i++) cycle($sformatf("restore%0d", i), 0, 0, '0, 0, 1, '0, 0);
    cycle("restore_trap", 0, 0, '0, 0, 1, 4'b0010, 0);
    cycle("unf_clear", 0, 0, '0, 0, 0, '0, 0);

    // forwarding vs no forwarding on r7
    cycle("w_r7", 1, 7, 32'h12345678, 0, 0, '0, 0);
    Le = 1; RD = 7; RA = 7; RB = 7; D = 32'hA5A5A5A5; #1;
    push_exp("byp_qa", 32'hA5A5A5A5);
    push_exp("byp_qb", 32'hA5A5A5A5);
    push_exp("nobyp_qa", 32'h12345678);
    push_exp("nobyp_qb", mread(7));
    pop_check(qa);
    pop_check(qb);
    pop_check(qa_nb);
    pop_check(qb_nb);
    cycle("w_r7b", 1, 7, 32'hA5A5A5A5, 0, 0, '0, 0);
    rd_chk(7, 7);

    // simultaneous save/restore ignored; reset beats everything
    cycle("save_restore", 0, 0, '0, 1, 1, 4'b1111, 0);
    cycle("w_r20", 1, 20, 32'hCAFE0001, 0, 0, '0, 0);
    cycle("pre_trap", 0, 0, '0, 1, 0, 4'b1111, 0);
    cycle("clr_prio", 1, 9, 32'hFFFF0000, 1, 0, 4'b1111, 1);
    push_exp("clr_cwp", 32'd0);
    push_exp("clr_ovf", 32'd0);
    pop_check(W'(cwp));
    pop_check(W'(ovf));
    for (int r = 1; r < 32; r += 2) rd_chk(r, r + 1 > 31 ? 31 : r + 1);

    // randomized traffic with pre-edge forwarding checks
    for (int it = 0; it < 80; it++) begin
      le  = 1'($urandom_range(0, 1));
      rd  = $urandom_range(0, 31);
      rb  = $urandom_range(0, 31);
      d   = $urandom;
      sv  = ($urandom_range(0, 3) == 0);
      rs  = ($urandom_range(0, 3) == 0);
      wim = ($urandom_range(0, 2) == 0) ? NW'($urandom) : '0;
      clr = ($urandom_range(0, 39) == 0);
      Le = le; RD = 5'(rd); D = d; RA = 5'(rd); RB = 5'(rb); #1;
      push_exp("rnd_byp_qa", (le && rd != 0) ? d : mread(rd));
      push_exp("rnd_byp_qb", (le && rb == rd && rb != 0) ? d : mread(rb));
      push_exp("rnd_nobyp_qa", mread(rd));
      pop_check(qa);
      pop_check(qb);
      pop_check(qa_nb);
      cycle($sformatf("rnd%0d", it), le, rd, d, sv, rs, wim, clr);
      push_exp("rnd_unf_nb", W'(m_unf));
      push_exp("rnd_ovf_nb", W'(m_ovf));
      pop_check(W'(unf_nb));
      pop_check(W'(ovf_nb));
      rd_chk($urandom_range(0, 31), $urandom_range(0, 31));
    end

    if (sb.size() != 0) chk("scoreboard_leftover", W'(sb.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
